// File: rtl/uart_tx.sv
//------------------------------------------------------------------------------
// uart_tx
//
// Purpose:
//   UART transmitter. It serialises one byte per accepted request into a frame
//   of one start bit, eight data bits sent LSB first, an optional parity bit
//   and one or two stop bits. Each serial bit lasts CLKS_PER_BIT system clocks.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 1)
//   PARITY_EN     1 = append a parity bit after the data bits
//   PARITY_ODD    parity sense when PARITY_EN = 1 (0 = even, 1 = odd)
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports:
//   clk   in   system clock; all logic runs on the rising edge
//   rst   in   asynchronous reset, active low
//   send  in   transmit request, sampled on the rising edge
//   data  in   byte to transmit, sampled only when send is accepted
//   busy  out  high while a frame is in progress
//   tx    out  serial line, idles high, driven straight from a flop
//------------------------------------------------------------------------------
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    // The counter can hold CLKS_PER_BIT itself, so it is never zero width.
    // This also covers CLKS_PER_BIT = 1.
    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // Index of the final stop bit. It is 0 for one stop bit and 1 for two.
    localparam logic STOP_LAST = (STOP_BITS == 2);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [2:0]       bit_idx_q,  bit_idx_d;
    logic             stop_idx_q, stop_idx_d;
    logic [7:0]       shift_q,    shift_d;
    logic             parity_q,   parity_d;
    logic             tx_q,       tx_d;
    logic             busy_q,     busy_d;

    logic             bit_done;
    logic             accept;

    // The current serial bit has been held for its full bit period.
    assign bit_done = (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every signal gets a default before the case statement. A
        // signal that some path leaves unassigned would infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        accept     = 1'b0;

        // The bit-period counter wraps at the end of every serial bit.
        // It stays cleared while idle.
        if (state_q != ST_IDLE) begin
            cnt_d = bit_done ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                accept = send;
            end

            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                end
            end

            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d    = PARITY_EN ? ST_PARITY : ST_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end

            ST_PARITY: begin
                if (bit_done) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                end
            end

            ST_STOP: begin
                if (bit_done) begin
                    if (stop_idx_q == STOP_LAST) begin
                        // The last cycle of the final stop bit also accepts
                        // send. A held request therefore puts the next start
                        // bit directly after the stop bit, with no idle
                        // cycle, and busy does not drop between frames.
                        state_d = ST_IDLE;
                        accept  = send;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The byte is read only in the accepting cycle. A stray or X value
        // on data at any other time cannot reach the line.
        if (accept) begin
            state_d  = ST_START;
            cnt_d    = '0;
            shift_d  = data;
            parity_d = (^data) ^ PARITY_ODD;
        end
    end

    // tx and busy are decoded from the next state and stored in flops. The
    // pin then changes in the same cycle as the state, with no decode glitches.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: the datapath flops (shift, parity) are reset along with the
    // control flops, so no X can reach tx after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            stop_idx_q <= 1'b0;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. All flops
            // then update together from values computed before the edge.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
//------------------------------------------------------------------------------
// tb_uart_tx
//
// Directed bench for uart_tx. It instantiates four configurations that share
// one clock and one reset:
//   sel 0: CLKS_PER_BIT=1, no parity, 1 stop bit
//   sel 1: CLKS_PER_BIT=4, no parity, 1 stop bit
//   sel 2: CLKS_PER_BIT=2, even parity, 2 stop bits
//   sel 3: CLKS_PER_BIT=1, odd parity, 1 stop bit
//
// Each expected frame is a hand-written string with one character per serial
// bit, in line order: start, d0..d7, [parity], stop(s).
//------------------------------------------------------------------------------
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic       send_drv;
    logic [7:0] data_drv;
    logic [1:0] sel;

    logic [3:0] send_v;
    logic [3:0] tx_v;
    logic [3:0] busy_v;
    logic       tx_mon;
    logic       busy_mon;

    int n_total;
    int n_pass;

    // Only the selected instance sees send.
    always_comb begin
        send_v      = 4'b0000;
        send_v[sel] = send_drv;
        tx_mon      = tx_v[sel];
        busy_mon    = busy_v[sel];
    end

    uart_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .send(send_v[0]), .data(data_drv), .busy(busy_v[0]), .tx(tx_v[0])
    );
    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .send(send_v[1]), .data(data_drv), .busy(busy_v[1]), .tx(tx_v[1])
    );
    uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .send(send_v[2]), .data(data_drv), .busy(busy_v[2]), .tx(tx_v[2])
    );
    uart_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u_dut3 (
        .clk(clk), .rst(rst), .send(send_v[3]), .data(data_drv), .busy(busy_v[3]), .tx(tx_v[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare the selected instance's outputs now.
    task automatic check_now(input string tag, input int idx, input logic exp_tx, input logic exp_busy);
        n_total++;
        assert (tx_mon === exp_tx) n_pass++;
        else $error("FAIL %s[%0d] tx: got %b expected %b", tag, idx, tx_mon, exp_tx);
        n_total++;
        assert (busy_mon === exp_busy) n_pass++;
        else $error("FAIL %s[%0d] busy: got %b expected %b", tag, idx, busy_mon, exp_busy);
    endtask

    // Compare on the falling edge, away from the active edge.
    task automatic check_cycle(input string tag, input int idx, input logic exp_tx, input logic exp_busy);
        @(negedge clk);
        check_now(tag, idx, exp_tx, exp_busy);
    endtask

    // Raise send with byte b at a falling edge. The next rising edge accepts it.
    task automatic kick(input logic [7:0] b);
        @(negedge clk);
        data_drv = b;
        send_drv = 1'b1;
    endtask

    // Walk one frame cycle by cycle. Cycle 0 is the first cycle after
    // acceptance. Send is released at cycle 0. Cycles p1 and p2 each raise a
    // one-cycle send pulse with data 8'hFF; these must be ignored.
    // ncyc > 0 stops early.
    task automatic run_frame(input string tag, input string bits, input int cpb,
                             input int p1, input int p2, input int ncyc);
        int total;
        total = bits.len() * cpb;
        if (ncyc > 0) total = ncyc;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            if (k == p1 || k == p2) begin
                send_drv = 1'b1;
                data_drv = 8'hFF;
            end else begin
                send_drv = 1'b0;
            end
            check_now(tag, k, (bits[k / cpb] == "1"), 1'b1);
        end
    endtask

    task automatic expect_idle(input string tag, input int n);
        for (int k = 0; k < n; k++) check_cycle(tag, k, 1'b1, 1'b0);
    endtask

    initial begin
        string b2b;
        n_total  = 0;
        n_pass   = 0;
        sel      = 2'd0;
        send_drv = 1'b0;
        data_drv = 8'h00;

        // Reset is held low for one clock, then released at a falling edge.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            check_now("reset", s, 1'b1, 1'b0);
        end
        sel = 2'd0;
        expect_idle("reset_hold", 3);

        // 'H' at one clock per bit: 0 | 00010010 | 1, busy for 10 cycles.
        sel = 2'd0;
        kick(8'h48);
        run_frame("h_cpb1", "0000100101", 1, -1, -1, 0);
        expect_idle("h_cpb1_idle", 3);

        // 8'hA5 at four clocks per bit, busy for 40 cycles.
        sel = 2'd1;
        kick(8'hA5);
        run_frame("a5_cpb4", "0101001011", 4, -1, -1, 0);
        expect_idle("a5_cpb4_idle", 2);

        // Send pulses with 8'hFF at frame cycles 3 and 6 must not alter the
        // frame for 8'h00. They must not queue a second frame either.
        kick(8'h00);
        run_frame("ignore", "0000000001", 4, 3, 6, 0);
        expect_idle("ignore_idle", 6);

        // Back-to-back with send held: 8'h55, then 8'h0F. Data changes to 8'h0F
        // during the first frame. Send drops once the second frame is visible.
        sel = 2'd0;
        b2b = "01010101010111100001";
        kick(8'h55);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) data_drv = 8'h0F;
            if (k == 10) send_drv = 1'b0;
            check_now("b2b", k, (b2b[k] == "1"), 1'b1);
        end
        expect_idle("b2b_idle", 3);

        // Reset asserted in the middle of the DATA bits. Outputs must go idle
        // before any clock edge.
        sel = 2'd1;
        kick(8'hA5);
        run_frame("pre_rst", "0101001011", 4, -1, -1, 14);
        #2 rst = 1'b0;
        #1 check_now("async_rst", 0, 1'b1, 1'b0);
        @(negedge clk);
        check_now("async_rst", 1, 1'b1, 1'b0);
        rst = 1'b1;
        expect_idle("post_rst_idle", 3);
        kick(8'h3C);
        run_frame("post_rst", "0001111001", 4, -1, -1, 0);
        expect_idle("post_rst_end", 2);

        // Even parity of 8'h07 is 1; two stop bits; two clocks per bit.
        sel = 2'd2;
        kick(8'h07);
        run_frame("par_even", "011100000111", 2, -1, -1, 0);
        expect_idle("par_even_idle", 2);

        // Odd parity of 8'h07 is 0.
        sel = 2'd3;
        kick(8'h07);
        run_frame("par_odd", "01110000001", 1, -1, -1, 0);
        expect_idle("par_odd_idle", 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
